// File: rtl/aes_decipher_iter.sv
// Iterative AES-128 decryption: forward key expansion to k10, then ten inverse rounds, one per clock.
// Optional AESDEC_KEYCACHE_EN keeps the last (key, k10) pair so a repeated key skips forward expansion.
module aes_decipher_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] datain,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dataout,
    output logic [127:0] keyout,
    output logic         busy
);
    localparam int unsigned BW = 128;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST = CW'(10);

    typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] st;
    logic [BW-1:0] rk;
    logic [CW-1:0] ridx;
    logic [31:0]   kw;
    logic [31:0]   sw;
    logic [31:0]   n0, n1, n2, n3;
    logic [BW-1:0] rk_next;
    logic [BW-1:0] rnd;

`ifdef AESDEC_KEYCACHE_EN
    logic          cache_valid;
    logic [BW-1:0] cache_key;
    logic [BW-1:0] cache_k10;
    logic [BW-1:0] key_q;
`endif

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Field inverse computed as a^254, which also maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rol(b, 1) ^ rol(b, 2) ^ rol(b, 3) ^ rol(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rol(a, 1) ^ rol(a, 3) ^ rol(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [CW-1:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // InvShiftRows + InvSubBytes + AddRoundKey, then optional InvMixColumns.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic mix);
        logic [7:0]   b [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                b[c*4+j] = inv_sbox(s[127-8*(((c-j+4)%4)*4+j) -: 8]) ^ k[127-8*(c*4+j) -: 8];
            end
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = b[c*4];
            a1 = b[c*4+1];
            a2 = b[c*4+2];
            a3 = b[c*4+3];
            if (mix) begin
                r[127-32*c -: 32] = {
                    gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                    gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                    gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                    gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
            end else begin
                r[127-32*c -: 32] = {a0, a1, a2, a3};
            end
        end
        return r;
    endfunction

    // Shared key step: forward expansion in KEXP, inverse expansion otherwise; one SubWord.
    always_comb begin
        ridx    = (state == KEXP) ? cnt : CW'(11) - cnt;
        kw      = (state == KEXP) ? rk[31:0] : (rk[31:0] ^ rk[63:32]);
        sw      = sub_word({kw[23:0], kw[31:24]}) ^ {rcon(ridx), 24'h000000};
        n0      = rk[127:96] ^ sw;
        n1      = rk[95:64] ^ n0;
        n2      = rk[63:32] ^ n1;
        n3      = rk[31:0] ^ n2;
        rk_next = {rk[127:96] ^ sw, rk[127:96] ^ rk[95:64], rk[95:64] ^ rk[63:32], kw};
        if (state == KEXP) rk_next = {n0, n1, n2, n3};
        rnd     = inv_round(st, rk_next, cnt != LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            dataout   <= '0;
            keyout    <= '0;
            cnt       <= '0;
            st        <= '0;
            rk        <= '0;
`ifdef AESDEC_KEYCACHE_EN
            cache_valid <= 1'b0;
            cache_key   <= '0;
            cache_k10   <= '0;
            key_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= CW'(1);
`ifdef AESDEC_KEYCACHE_EN
                        key_q <= key;
                        if (cache_valid && (key == cache_key)) begin
                            rk    <= cache_k10;
                            st    <= datain ^ cache_k10;
                            state <= DEC;
                        end else begin
                            rk    <= key;
                            st    <= datain;
                            state <= KEXP;
                        end
`else
                        rk    <= key;
                        st    <= datain;
                        state <= KEXP;
`endif
                    end
                end
                KEXP: begin
                    rk <= rk_next;
                    if (cnt == LAST) begin
                        st    <= st ^ rk_next;
                        cnt   <= CW'(1);
                        state <= DEC;
`ifdef AESDEC_KEYCACHE_EN
                        cache_valid <= 1'b1;
                        cache_key   <= key_q;
                        cache_k10   <= rk_next;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DEC: begin
                    rk <= rk_next;
                    st <= rnd;
                    if (cnt == LAST) begin
                        dataout   <= rnd;
                        keyout    <= rk_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
